layer_output_serializer: RTL and testbench

- Consumer end of the 8-channel packed conv-layer output stream (8 × 32-bit words, qualified only by Valid_In).
- The upstream layer has no backpressure, so this block buffers whole pixels in a FIFO.
- It emits one channel word per handshake on a valid/ready interface, channel 0 first, with channel index, pixel position and end-of-frame flag.
- It feeds the next layer's input stream or a memory writer.

---
 rtl/layer_ser_pkg.sv | 16 +
 rtl/sync_fifo_packed.sv | 67 ++++++
 rtl/layer_output_serializer.sv | 159 +++++++++++++++
 tb/tb_layer_output_serializer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_ser_pkg.sv
// Shared types and helpers for the layer output serializer and its FIFO.
package layer_ser_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_e;

    localparam int unsigned NUM_CH_DEFAULT = 8;

    function automatic int unsigned ch_slice_width(input int unsigned total_w,
                                                   input int unsigned num_ch);
        return total_w / num_ch;
    endfunction

endpackage

// File: rtl/sync_fifo_packed.sv
// Synchronous FIFO with occupancy count. A push is accepted when full if a pop happens
// in the same cycle. Depth must be a power of two.
module sync_fifo_packed #(
    parameter int unsigned Width = 256,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW  = $clog2(Depth) + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_en, pop_en;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign pop_en  = pop_i & ~empty_o;
    assign push_en = push_i & (~full_o | pop_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
        count_d = count_q + CntW'(push_en) - CntW'(pop_en);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries covered by count_q are ever read.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/layer_output_serializer.sv
// Buffers packed conv-layer pixels and emits them one channel word per valid/ready handshake.
// Define SER_DROP_COUNT_EN to add the saturating Drop_Count output.
module layer_output_serializer
    import layer_ser_pkg::*;
#(
    parameter int unsigned DATA_WIDHT = 32,
    parameter int unsigned NUM_CH     = NUM_CH_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned IMG_WIDTH  = 218,
    parameter int unsigned IMG_HEIGHT = 218
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDHT*NUM_CH-1:0]   Data_In,
    input  logic                           Valid_In,
    output logic [DATA_WIDHT-1:0]          Data_Out,
    output logic                           Valid_Out,
    input  logic                           Ready_In,
    output logic [$clog2(NUM_CH)-1:0]      Ch_Idx,
    output logic [$clog2(IMG_WIDTH)-1:0]   Col_Idx,
    output logic [$clog2(IMG_HEIGHT)-1:0]  Row_Idx,
    output logic                           Last_Out,
    output logic                           Overflow,
`ifdef SER_DROP_COUNT_EN
    output logic [15:0]                    Drop_Count,
`endif
    output logic [$clog2(FIFO_DEPTH):0]    Fifo_Count
);

    localparam int unsigned PixW   = DATA_WIDHT * NUM_CH;
    localparam int unsigned SliceW = ch_slice_width(PixW, NUM_CH);
    localparam int unsigned ChW    = $clog2(NUM_CH);
    localparam int unsigned ColW   = $clog2(IMG_WIDTH);
    localparam int unsigned RowW   = $clog2(IMG_HEIGHT);

    ser_state_e        state_q, state_d;
    logic [PixW-1:0]   pix_q, pix_d;
    logic [ChW-1:0]    ch_q, ch_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [RowW-1:0]   row_q, row_d;
    logic              ovf_q, ovf_d;

    logic [PixW-1:0]   fifo_rdata;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic              send, drop;
    logic [NUM_CH-1:0][SliceW-1:0] pix_words;

    sync_fifo_packed #(
        .Width (PixW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (Valid_In),
        .pop_i   (fifo_pop),
        .wdata_i (Data_In),
        .rdata_o (fifo_rdata),
        .count_o (Fifo_Count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        ch_d     = ch_q;
        col_d    = col_q;
        row_d    = row_q;
        fifo_pop = 1'b0;
        send     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    pix_d    = fifo_rdata;
                    ch_d     = '0;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                send = 1'b1;
                if (Ready_In) begin
                    if (ch_q != ChW'(NUM_CH - 1)) begin
                        ch_d = ch_q + ChW'(1);
                    end else begin
                        ch_d = '0;
                        if (col_q == ColW'(IMG_WIDTH - 1)) begin
                            col_d = '0;
                            row_d = (row_q == RowW'(IMG_HEIGHT - 1)) ? '0 : row_q + RowW'(1);
                        end else begin
                            col_d = col_q + ColW'(1);
                        end
                        // Back-to-back pixels: reload in the same cycle, no idle bubble.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            pix_d    = fifo_rdata;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign drop  = Valid_In & fifo_full & ~fifo_pop;
    assign ovf_d = ovf_q | drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            ch_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            ch_q    <= ch_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef SER_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign Drop_Count = drop_cnt_q;
`endif

    assign pix_words = pix_q;
    assign Valid_Out = send;
    assign Data_Out  = send ? pix_words[ch_q] : '0;
    assign Ch_Idx    = ch_q;
    assign Col_Idx   = col_q;
    assign Row_Idx   = row_q;
    assign Overflow  = ovf_q;
    assign Last_Out  = send && (ch_q == ChW'(NUM_CH - 1)) && (col_q == ColW'(IMG_WIDTH - 1))
                       && (row_q == RowW'(IMG_HEIGHT - 1));

endmodule

// File: tb/tb_layer_output_serializer.sv
// Randomized and directed bench for layer_output_serializer against a queue-based pixel model.
module tb_layer_output_serializer;

    localparam int unsigned DW    = 32;
    localparam int unsigned NCH   = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned W     = 4;
    localparam int unsigned H     = 3;

    typedef logic [DW*NCH-1:0] pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    pix_t        Data_In = '0;
    logic        Valid_In = 1'b0;
    logic        Ready_In = 1'b0;
    logic [DW-1:0] Data_Out;
    logic        Valid_Out;
    logic [2:0]  Ch_Idx;
    logic [1:0]  Col_Idx;
    logic [1:0]  Row_Idx;
    logic        Last_Out;
    logic        Overflow;
    logic [4:0]  Fifo_Count;
`ifdef SER_DROP_COUNT_EN
    logic [15:0] Drop_Count;
`endif

    always #5 clk = ~clk;

    layer_output_serializer #(
        .DATA_WIDHT (DW),
        .NUM_CH     (NCH),
        .FIFO_DEPTH (DEPTH),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Data_In    (Data_In),
        .Valid_In   (Valid_In),
        .Data_Out   (Data_Out),
        .Valid_Out  (Valid_Out),
        .Ready_In   (Ready_In),
        .Ch_Idx     (Ch_Idx),
        .Col_Idx    (Col_Idx),
        .Row_Idx    (Row_Idx),
        .Last_Out   (Last_Out),
        .Overflow   (Overflow),
`ifdef SER_DROP_COUNT_EN
        .Drop_Count (Drop_Count),
`endif
        .Fifo_Count (Fifo_Count)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of buffered pixels plus the pixel being sent.
    pix_t q_m[$];
    pix_t cur_m;
    bit   busy_m;
    int   ch_m, col_m, row_m, drops_m;
    bit   ovf_m;
    int   hs_obs, last_obs, last_word_obs;

    function automatic pix_t mk_pix(input logic [31:0] base);
        pix_t p;
        for (int k = 0; k < NCH; k++) p[k*DW +: DW] = base + k;
        return p;
    endfunction

    function automatic pix_t rand_pix();
        pix_t p;
        for (int k = 0; k < NCH; k++) p[k*DW +: DW] = $urandom;
        return p;
    endfunction

    task automatic model_clear();
        q_m.delete();
        cur_m   = '0;
        busy_m  = 0;
        ch_m    = 0;
        col_m   = 0;
        row_m   = 0;
        ovf_m   = 0;
        drops_m = 0;
    endtask

    task automatic compare_outputs();
        bit last_e;
        last_e = busy_m && ch_m == NCH - 1 && col_m == W - 1 && row_m == H - 1;
        check_eq("valid", Valid_Out, busy_m);
        if (busy_m) check_eq("data", Data_Out, cur_m[ch_m*DW +: DW]);
        check_eq("ch", Ch_Idx, ch_m);
        check_eq("col", Col_Idx, col_m);
        check_eq("row", Row_Idx, row_m);
        check_eq("last", Last_Out, last_e);
        check_eq("ovf", Overflow, ovf_m);
        check_eq("count", Fifo_Count, q_m.size());
`ifdef SER_DROP_COUNT_EN
        check_eq("drops", Drop_Count, drops_m);
`endif
    endtask

    task automatic model_edge(input bit v, input pix_t d, input bit r);
        int pre;
        bit pop;
        pre = q_m.size();
        pop = 0;
        if (!busy_m) begin
            if (pre > 0) begin
                cur_m  = q_m.pop_front();
                busy_m = 1;
                ch_m   = 0;
                pop    = 1;
            end
        end else if (r) begin
            if (ch_m < NCH - 1) begin
                ch_m++;
            end else begin
                ch_m = 0;
                if (col_m == W - 1) begin
                    col_m = 0;
                    row_m = (row_m == H - 1) ? 0 : row_m + 1;
                end else begin
                    col_m++;
                end
                if (pre > 0) begin
                    cur_m = q_m.pop_front();
                    pop   = 1;
                end else begin
                    busy_m = 0;
                end
            end
        end
        if (v) begin
            if (pre < DEPTH || pop) begin
                q_m.push_back(d);
            end else begin
                ovf_m = 1;
                if (drops_m < 16'hFFFF) drops_m++;
            end
        end
    endtask

    // One cycle: check outputs, drive next inputs, advance the model across the coming edge.
    task automatic step(input bit v, input pix_t d, input bit r);
        @(negedge clk);
        compare_outputs();
        Valid_In = v;
        Data_In  = d;
        Ready_In = r;
        if (Valid_Out && r) begin
            hs_obs++;
            if (Last_Out) begin
                last_obs++;
                last_word_obs = hs_obs;
            end
        end
        model_edge(v, d, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst      = 1'b0;
        Valid_In = 1'b0;
        Ready_In = 1'b0;
        #1;
        check_eq("rst_valid", Valid_Out, 0);
        check_eq("rst_count", Fifo_Count, 0);
        check_eq("rst_ch", Ch_Idx, 0);
        check_eq("rst_col", Col_Idx, 0);
        check_eq("rst_row", Row_Idx, 0);
        check_eq("rst_ovf", Overflow, 0);
        check_eq("rst_last", Last_Out, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int lat;
        bit hit;
        model_clear();
        hs_obs = 0;
        last_obs = 0;
        last_word_obs = 0;
        do_reset();

        // Single pixel with latency measurement.
        step(1, mk_pix(32'h3F80_0000), 1);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, '0, 1);
            lat++;
            if (Valid_Out) break;
        end
        check_eq("latency", lat, 2);
        repeat (10) step(0, '0, 1);

        // Backpressure pattern 1,0,0.
        step(1, mk_pix(32'h4000_0000), 1);
        for (int i = 0; i < 30; i++) step(0, '0, (i % 3) == 0);

        // Overflow: fill while stalled; one pixel sits in the shift register.
        do_reset();
        for (int i = 0; i < 18; i++) step(1, mk_pix(32'h1000_0000 + (i << 8)), 0);
        step(0, '0, 0);
        check_eq("ovf_set", Overflow, 1);
        check_eq("ovf_full", Fifo_Count, DEPTH);
        repeat (5) step(0, '0, 0);
        check_eq("ovf_sticky", Overflow, 1);
        hs_obs = 0;
        repeat (160) step(0, '0, 1);
        check_eq("ovf_words", hs_obs, 17 * NCH);
        check_eq("ovf_still", Overflow, 1);

        // Push into a full FIFO on the same cycle as the last-channel pop.
        do_reset();
        for (int i = 0; i < 17; i++) step(1, mk_pix(32'h2000_0000 + (i << 8)), 0);
        for (int i = 0; i < 40; i++) begin
            hit = busy_m && ch_m == NCH - 1 && q_m.size() == DEPTH;
            step(hit, mk_pix(32'h2800_0000 + (i << 8)), 1);
        end
        check_eq("pp_ovf", Overflow, 0);
        check_eq("pp_count", Fifo_Count, DEPTH);
        repeat (200) step(0, '0, 1);

        // Frame wrap: 13 pixels spaced NCH cycles apart.
        do_reset();
        hs_obs = 0;
        last_obs = 0;
        last_word_obs = 0;
        for (int p = 0; p < 13; p++) begin
            step(1, mk_pix(32'h5000_0000 + (p << 8)), 1);
            repeat (NCH - 1) step(0, '0, 1);
        end
        repeat (20) step(0, '0, 1);
        check_eq("frame_last_cnt", last_obs, 1);
        check_eq("frame_last_word", last_word_obs, W * H * NCH);
        check_eq("frame_words", hs_obs, 13 * NCH);

        // Async reset in the middle of a pixel.
        step(1, mk_pix(32'h6000_0000), 1);
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, '0, 1);
            if (busy_m && ch_m == 3) begin
                hit = 1;
                break;
            end
        end
        check_eq("mid_reached", hit, 1);
        do_reset();
        step(1, mk_pix(32'h7000_0000), 1);
        repeat (12) step(0, '0, 1);

        // Random traffic with random backpressure and occasional bursts.
        for (int i = 0; i < 2500; i++) begin
            bit v;
            if ((i / 250) % 4 == 3) v = ($urandom_range(0, 1) == 0);
            else v = ($urandom_range(0, 9) == 0);
            step(v, rand_pix(), $urandom_range(0, 3) != 0);
        end
        repeat (200) step(0, '0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
